// File: rtl/wm_cycle_ctrl.sv
// wm_cycle_ctrl: washing-machine cycle controller.
//   Sequences FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE from start/pause
//   button pulses. Each phase runs for its *_CYCLES parameter in clk cycles.
//   Optional macro WM_EXTRA_RINSE_EN inserts RINSE2 (state 7) between RINSE
//   and SPIN; without it state 7 is illegal and recovers to IDLE.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start_button  start request (edge detected, held button = one request)
//   pause_button  pause/resume toggle (edge detected)
//   valve_in      water inlet enable        (registered)
//   valve_out     drain pump enable         (registered)
//   motor         drum motor enable         (registered)
//   state         current phase code        (registered)
//   paused        cycle frozen by pause     (registered)
//   out           cycle complete, high in DONE (registered)
module wm_cycle_ctrl #(
    parameter int unsigned FILL_CYCLES  = 8,
    parameter int unsigned WASH_CYCLES  = 16,
    parameter int unsigned DRAIN_CYCLES = 6,
    parameter int unsigned RINSE_CYCLES = 10,
    parameter int unsigned SPIN_CYCLES  = 12,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_button,
    input  logic       pause_button,
    output logic       valve_in,
    output logic       valve_out,
    output logic       motor,
    output logic [2:0] state,
    output logic       paused,
    output logic       out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_WASH   = 3'd2,
        S_DRAIN  = 3'd3,
        S_RINSE  = 3'd4,
        S_SPIN   = 3'd5,
        S_DONE   = 3'd6,
        S_RINSE2 = 3'd7
    } phase_t;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] LD_FILL  = CNT_W'(FILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WASH  = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_DRAIN = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RINSE = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_SPIN  = CNT_W'(SPIN_CYCLES - 1);

    phase_t           cur;
    logic [CNT_W-1:0] cnt;
    logic             start_q;
    logic             pause_q;
    logic             start_rise_c;
    logic             pause_rise_c;

    assign start_rise_c = start_button & ~start_q;
    assign pause_rise_c = pause_button & ~pause_q;
    assign state        = cur;

    // Phase that follows p once its count expires.
    function automatic phase_t phase_after(input phase_t p);
        phase_t n;
        n = S_IDLE;
        case (p)
            S_FILL:   n = S_WASH;
            S_WASH:   n = S_DRAIN;
            S_DRAIN:  n = S_RINSE;
`ifdef WM_EXTRA_RINSE_EN
            S_RINSE:  n = S_RINSE2;
            S_RINSE2: n = S_SPIN;
`else
            S_RINSE:  n = S_SPIN;
`endif
            S_SPIN:   n = S_DONE;
            default:  n = S_IDLE;
        endcase
        return n;
    endfunction

    // Counter load on entry to phase p.
    function automatic logic [CNT_W-1:0] phase_load(input phase_t p);
        logic [CNT_W-1:0] v;
        v = '0;
        case (p)
            S_FILL:   v = LD_FILL;
            S_WASH:   v = LD_WASH;
            S_DRAIN:  v = LD_DRAIN;
            S_RINSE:  v = LD_RINSE;
            S_RINSE2: v = LD_RINSE;
            S_SPIN:   v = LD_SPIN;
            default:  v = '0;
        endcase
        return v;
    endfunction

    // Actuator map for an unpaused phase: {valve_in, valve_out, motor}.
    function automatic logic [2:0] act_map(input phase_t p);
        logic [2:0] a;
        a = 3'b000;
        case (p)
            S_FILL:   a = 3'b100;
            S_WASH:   a = 3'b001;
            S_DRAIN:  a = 3'b010;
            S_RINSE:  a = 3'b101;
            S_RINSE2: a = 3'b101;
            S_SPIN:   a = 3'b011;
            default:  a = 3'b000;
        endcase
        return a;
    endfunction

    // Phases in which the counter runs; RINSE2 only exists with the macro.
    function automatic logic is_active(input phase_t p);
        logic r;
        r = 1'b0;
        case (p)
            S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: r = 1'b1;
`ifdef WM_EXTRA_RINSE_EN
            S_RINSE2: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Phase sequencer; actuators and flags are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur       <= S_IDLE;
            cnt       <= '0;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            paused    <= 1'b0;
            out       <= 1'b0;
            valve_in  <= 1'b0;
            valve_out <= 1'b0;
            motor     <= 1'b0;
        end else begin
            start_q <= start_button;
            pause_q <= pause_button;
            if (cur == S_IDLE || cur == S_DONE) begin
                // pause is ignored here; start launches a fresh cycle
                if (start_rise_c) begin
                    cur                          <= S_FILL;
                    cnt                          <= LD_FILL;
                    paused                       <= 1'b0;
                    out                          <= 1'b0;
                    {valve_in, valve_out, motor} <= act_map(S_FILL);
                end
            end else if (is_active(cur)) begin
                if (pause_rise_c && !paused) begin
                    // entering pause freezes this edge, including a pending
                    // phase transition at count zero
                    paused                       <= 1'b1;
                    {valve_in, valve_out, motor} <= 3'b000;
                end else if (!paused || pause_rise_c) begin
                    // running, or resuming: the resume edge counts normally so
                    // frozen cycles equal the cycles spent paused
                    paused <= 1'b0;
                    if (cnt == '0) begin
                        cur                          <= phase_after(cur);
                        cnt                          <= phase_load(phase_after(cur));
                        out                          <= (phase_after(cur) == S_DONE);
                        {valve_in, valve_out, motor} <= act_map(phase_after(cur));
                    end else begin
                        cnt                          <= cnt - CNT_W'(1);
                        {valve_in, valve_out, motor} <= act_map(cur);
                    end
                end
            end else begin
                // illegal encoding: fall back to a quiet IDLE
                cur                          <= S_IDLE;
                cnt                          <= '0;
                paused                       <= 1'b0;
                out                          <= 1'b0;
                {valve_in, valve_out, motor} <= 3'b000;
            end
        end
    end

endmodule

// File: doc/wm_cycle_ctrl.md
Name: wm_cycle_ctrl

Overview:
- Washing-machine cycle controller. Consumes start/pause button pulses and sequences FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE.
- Each phase runs from a parameterised cycle count.
- Drives valve and motor enables plus a done/status output.
- It is the responding end of the button stimulus interface; it sits under the machine top level, between the button inputs and the actuator drivers.

Parameters:
- FILL_CYCLES, 8, FILL phase length in clk cycles (>=1)
- WASH_CYCLES, 16, WASH phase length (>=1)
- DRAIN_CYCLES, 6, DRAIN phase length (>=1)
- RINSE_CYCLES, 10, RINSE phase length (>=1)
- SPIN_CYCLES, 12, SPIN phase length (>=1)
- CNT_W, 16, phase counter width; every *_CYCLES must be <= 2^CNT_W

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start_button  input  1  start request, synchronous to clk, high >=1 cycle
- pause_button  input  1  pause/resume toggle, synchronous to clk, high >=1 cycle
- valve_in  output  1  water inlet enable
- valve_out  output  1  drain pump enable
- motor  output  1  drum motor enable
- state  output  3  current phase: IDLE=0 FILL=1 WASH=2 DRAIN=3 RINSE=4 SPIN=5 DONE=6 RINSE2=7
- paused  output  1  cycle frozen by pause
- out  output  1  cycle complete (high in DONE)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; paused=0; out=0; all actuators 0; counter=0.
  - Button history registers cleared.
  - Reset asserted mid-cycle aborts immediately to IDLE; no resume.
- Edge detect:
  - start_rise = start_button & ~start_q; pause_rise likewise. The *_q registers sample every clk.
  - A held button produces exactly one rise.
  - Rises are acted on at the same clk edge where they are sampled. Response latency is 1 clk, and all outputs are registered.
- IDLE/DONE:
  - start_rise -> FILL; counter=FILL_CYCLES-1; out=0.
  - pause_rise is ignored in IDLE and DONE.
- Active phase, paused=0:
  - Counter decrements by 1 each clk.
  - When counter==0, advance to the next phase and load its *_CYCLES-1.
  - Each phase is therefore exactly N clk cycles long.
  - SPIN with counter==0 -> DONE: out=1, held until the next start_rise.
- Pause:
  - pause_rise in an active phase toggles paused.
  - While paused=1: counter and state frozen; valve_in, valve_out and motor forced to 0; start_rise ignored.
  - Unpausing resumes with the remaining count unchanged. The total active cycles for the phase are unaffected by pause.
- Simultaneous events:
  - start_rise and pause_rise in the same cycle in IDLE/DONE: start wins, paused stays 0.
  - In an active phase: pause is honoured, start is ignored.
  - pause_rise on the cycle where counter==0: the pause takes effect and the phase transition is suppressed, so the phase is not advanced.
- Actuator map (unpaused):
  - FILL: valve_in=1
  - WASH: motor=1
  - DRAIN: valve_out=1
  - RINSE / RINSE2: valve_in=1, motor=1
  - SPIN: motor=1, valve_out=1
  - IDLE / DONE: all 0
- Illegal state value: recover to IDLE on the next clk.

Optional Feature:
- Macro WM_EXTRA_RINSE_EN.
- Defined: RINSE -> RINSE2 (state 7, RINSE_CYCLES long) -> SPIN. Total active length = FILL+WASH+DRAIN+2*RINSE+SPIN.
- Undefined: RINSE -> SPIN; state 7 is unreachable and treated as illegal.

Test Plan:
- Reset then start_button pulse 1 clk with default parameters:
  - state=1 next clk.
  - Phase lengths 8/16/6/10/12 clk.
  - out=1 exactly 52 clk after FILL entry.
  - Actuators match the map at every phase.
- Start held high for 5 clk: only one cycle is launched. A second pulse during WASH has no effect and the timeline is unchanged.
- Pause at WASH counter=9, hold paused for 20 clk, then resume:
  - paused=1 for exactly 20 clk; motor=0 throughout; state=2 frozen.
  - DONE reached 20 clk later than the unpaused run (72).
- Start and pause asserted in the same clk from IDLE: state=FILL, paused=0.
- reset=0 asserted mid-RINSE without waiting for a clk edge: all outputs 0 and state=0 immediately. A subsequent start runs the full 52-clk cycle.
- With WM_EXTRA_RINSE_EN defined: state sequence 1,2,3,4,7,5,6; DONE at 62 clk.
